// File: rtl/operand_prep_pipe_if.sv
// Handshake and data bundle between the instruction source, the operand
// preprocessor and the adder. The slave modport is the preprocessor's view.
interface operand_prep_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             cf_we;
  logic             cf_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a_mod;
  logic [WIDTH-1:0] b_mod;
  logic             cin;
  logic [2:0]       op_out;
  logic             cf_q;

  modport slave (
    input  in_valid, in_a, in_b, in_op, cf_we, cf_in, out_ready,
    output in_ready, out_valid, a_mod, b_mod, cin, op_out, cf_q
  );

  modport master (
    output in_valid, in_a, in_b, in_op, cf_we, cf_in, out_ready,
    input  in_ready, out_valid, a_mod, b_mod, cin, op_out, cf_q
  );
endinterface

// File: rtl/operand_prep_pipe.sv
// Operand preprocessor: decodes opcode into A', B', cin for a single adder,
// behind a valid/ready handshake with an output register plus one skid entry.
module operand_prep_pipe #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  operand_prep_pipe_if.slave     bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_NEG  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_ADC  = 3'b111;

  logic             r_full0;
  logic [WIDTH-1:0] r_a0;
  logic [WIDTH-1:0] r_b0;
  logic             r_cin0;
  logic [2:0]       r_op0;
  logic             r_full1;
  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_b1;
  logic             r_cin1;
  logic [2:0]       r_op1;
  logic             r_cf;

  logic             w_cf_eff;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_acc;
  logic             w_xfer;

  // Carry written this cycle is visible to an ADC accepted in the same cycle.
  assign w_cf_eff = bus.cf_we ? bus.cf_in : r_cf;
  assign w_acc    = bus.in_valid && !r_full1;
  assign w_xfer   = r_full0 && bus.out_ready;

  always_comb begin
    w_a   = bus.in_a;
    w_b   = '0;
    w_cin = 1'b0;
    case (bus.in_op)
      OP_ADD:  begin w_b = bus.in_b;               end
      OP_SUB:  begin w_b = ~bus.in_b; w_cin = 1'b1; end
      OP_INC:  begin w_cin = 1'b1;                 end
      OP_DEC:  begin w_b = '1;                     end
      OP_NEG:  begin w_a = '0; w_b = ~bus.in_a; w_cin = 1'b1; end
      OP_NOT:  begin w_a = '0; w_b = ~bus.in_a;    end
      OP_PASS: begin                               end
      OP_ADC:  begin w_b = bus.in_b; w_cin = w_cf_eff; end
      default: begin                               end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cf <= 1'b0;
    end else if (bus.cf_we) begin
      r_cf <= bus.cf_in;
    end
  end

  // Skid refill and input accept are mutually exclusive: in_ready is low
  // whenever the skid holds an entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full0 <= 1'b0;
      r_a0    <= '0;
      r_b0    <= '0;
      r_cin0  <= 1'b0;
      r_op0   <= 3'b000;
      r_full1 <= 1'b0;
      r_a1    <= '0;
      r_b1    <= '0;
      r_cin1  <= 1'b0;
      r_op1   <= 3'b000;
    end else if (w_xfer && r_full1) begin
      r_a0    <= r_a1;
      r_b0    <= r_b1;
      r_cin0  <= r_cin1;
      r_op0   <= r_op1;
      r_full1 <= 1'b0;
    end else if (w_acc && (!r_full0 || w_xfer)) begin
      r_full0 <= 1'b1;
      r_a0    <= w_a;
      r_b0    <= w_b;
      r_cin0  <= w_cin;
      r_op0   <= bus.in_op;
    end else if (w_acc) begin
      r_full1 <= 1'b1;
      r_a1    <= w_a;
      r_b1    <= w_b;
      r_cin1  <= w_cin;
      r_op1   <= bus.in_op;
    end else if (w_xfer) begin
      r_full0 <= 1'b0;
    end
  end

  assign bus.in_ready  = !r_full1;
  assign bus.out_valid = r_full0;
  assign bus.a_mod     = r_a0;
  assign bus.b_mod     = r_b0;
  assign bus.cin       = r_cin0;
  assign bus.op_out    = r_op0;
  assign bus.cf_q      = r_cf;

endmodule

// File: tb/tb_operand_prep_pipe.sv
// Self-checking bench for operand_prep_pipe: vector table, stall/carry/reset
// sequences and a random stream, all checked through an ordered scoreboard.
module tb_operand_prep_pipe;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [2:0] op;
  } res_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_cf;
  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  operand_prep_pipe_if #(.WIDTH(4))  bus();
  operand_prep_pipe_if #(.WIDTH(16)) bus16();

  operand_prep_pipe #(.WIDTH(4))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  operand_prep_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         m_cf <= 1'b0;
    else if (bus.cf_we) m_cf <= bus.cf_in;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic cfe);
    res_t r;
    r.op = op;
    case (op)
      3'd0:    begin r.a = a;    r.b = b;       r.cin = 1'b0; end
      3'd1:    begin r.a = a;    r.b = ~b;      r.cin = 1'b1; end
      3'd2:    begin r.a = a;    r.b = 4'h0;    r.cin = 1'b1; end
      3'd3:    begin r.a = a;    r.b = 4'hF;    r.cin = 1'b0; end
      3'd4:    begin r.a = 4'h0; r.b = ~a;      r.cin = 1'b1; end
      3'd5:    begin r.a = 4'h0; r.b = ~a;      r.cin = 1'b0; end
      3'd6:    begin r.a = a;    r.b = 4'h0;    r.cin = 1'b0; end
      default: begin r.a = a;    r.b = b;       r.cin = cfe;  end
    endcase
    return r;
  endfunction

  // Output monitor: every transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        res_t e;
        res_t g;
        e = sb_q.pop_front();
        g = '{a: bus.a_mod, b: bus.b_mod, cin: bus.cin, op: bus.op_out};
        chk("sb_result", 64'(g), 64'(e));
      end
    end
  end

  // Offer one operation, push its expected result at the edge it is accepted.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic we, input logic ci, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    bus.cf_we = we;
    bus.cf_in = ci;
    while (!acc && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back(model(op, a, b, we ? ci : m_cf));
        acc = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
    bus.cf_we = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   w;
    int   tot;
    bit   rand_done;

    vt[0] = '{3'd0, 4'h6, 4'h9, '{4'h6, 4'h9, 1'b0, 3'd0}};
    vt[1] = '{3'd1, 4'h6, 4'h9, '{4'h6, 4'h6, 1'b1, 3'd1}};
    vt[2] = '{3'd2, 4'h6, 4'h9, '{4'h6, 4'h0, 1'b1, 3'd2}};
    vt[3] = '{3'd3, 4'h6, 4'h9, '{4'h6, 4'hF, 1'b0, 3'd3}};
    vt[4] = '{3'd4, 4'h6, 4'h9, '{4'h0, 4'h9, 1'b1, 3'd4}};
    vt[5] = '{3'd5, 4'h6, 4'h9, '{4'h0, 4'h9, 1'b0, 3'd5}};
    vt[6] = '{3'd6, 4'h6, 4'h9, '{4'h6, 4'h0, 1'b0, 3'd6}};
    vt[7] = '{3'd7, 4'h6, 4'h9, '{4'h6, 4'h9, 1'b0, 3'd7}};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
    bus.cf_we = 1'b0; bus.cf_in = 1'b0; bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_op = '0;
    bus16.cf_we = 1'b0; bus16.cf_in = 1'b0; bus16.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_a_mod", 64'(bus.a_mod), 64'd0);
    chk("rst_cf_q", 64'(bus.cf_q), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single SUB, one-cycle latency
    send(3'd1, 4'h5, 4'h3, 1'b0, 1'b0, w);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("sub_valid", 64'(bus.out_valid), 64'd1);
    chk("sub_a", 64'(bus.a_mod), 64'h5);
    chk("sub_b", 64'(bus.b_mod), 64'hC);
    chk("sub_cin", 64'(bus.cin), 64'd1);
    chk("sub_op", 64'(bus.op_out), 64'd1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    drain();

    // All opcodes back to back against hand-computed table
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_op = vt[i].op; bus.in_a = vt[i].a; bus.in_b = vt[i].b;
      @(negedge clk);
      if (bus.in_ready) sb_q.push_back(vt[i].exp);
      else tot++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("stream_stalls", 64'(tot), 64'd0);
    drain();

    // Stall: two buffered, third blocked, then ordered release
    bus.out_ready = 1'b0;
    send(3'd0, 4'h1, 4'h2, 1'b0, 1'b0, w);
    send(3'd1, 4'h3, 4'h4, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_a0", 64'(bus.a_mod), 64'h1);
    fork
      send(3'd2, 4'h7, 4'h0, 1'b0, 1'b0, w);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("stall_hold_a", 64'(bus.a_mod), 64'h1);
          chk("stall_hold_b", 64'(bus.b_mod), 64'h2);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    chk("third_waited", 64'(w > 0), 64'd1);
    drain();

    // Carry captured at accept; later cf write must not alter it
    bus.out_ready = 1'b0;
    send(3'd7, 4'hF, 4'h0, 1'b1, 1'b1, w);
    bus.cf_we = 1'b1; bus.cf_in = 1'b0;
    @(posedge clk); #1 bus.cf_we = 1'b0;
    @(negedge clk);
    chk("adc_cin_held", 64'(bus.cin), 64'd1);
    chk("adc_cf_q", 64'(bus.cf_q), 64'd0);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    drain();

    // Async reset with both entries full
    bus.cf_we = 1'b1; bus.cf_in = 1'b1;
    @(posedge clk); #1 bus.cf_we = 1'b0;
    bus.out_ready = 1'b0;
    send(3'd0, 4'hA, 4'h5, 1'b0, 1'b0, w);
    send(3'd6, 4'hB, 4'h5, 1'b0, 1'b0, w);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_cf_q", 64'(bus.cf_q), 64'd0);
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Wide instance boundary: SUB 0x0001, 0xFFFF
    bus16.in_valid = 1'b1; bus16.in_op = 3'd1; bus16.in_a = 16'h0001; bus16.in_b = 16'hFFFF;
    @(posedge clk); #1 bus16.in_valid = 1'b0;
    @(negedge clk);
    chk("w16_valid", 64'(bus16.out_valid), 64'd1);
    chk("w16_a", 64'(bus16.a_mod), 64'h0001);
    chk("w16_b", 64'(bus16.b_mod), 64'h0000);
    chk("w16_cin", 64'(bus16.cin), 64'd1);
    @(posedge clk); #1;

    // Random stream with random output stalls and carry writes
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
               ($urandom_range(0, 3) == 0), 1'($urandom), w);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1 bus.out_ready = 1'($urandom);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
